pong_frame_decoder: RTL and testbench
=====================================

# pong_frame_decoder

Consumes the 10-byte frames assembled by the SPI receive stage and turns them into validated game state for the renderer. On each new frame it snapshots the byte array, checks sync, XOR checksum, field ranges and (optionally) sequence continuity over a small FSM, then commits or drops the frame. It sits between the SPI controller and the pong display/game logic and holds the last good state indefinitely.

## Interface
- SYNC_BYTE, 8'hA5, required value of byte 0
- X_MAX, 639, largest legal ball x
- Y_MAX, 479, largest legal ball y
- sys_clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- data_i  in  8 x [0:9]  frame bytes from the SPI stage
- data_ready_i  in  1  level; high while data_i holds a complete frame
- paddle_l_o  out  8  left paddle y
- paddle_r_o  out  8  right paddle y
- ball_x_o  out  10  ball x
- ball_y_o  out  10  ball y
- score_l_o  out  4  left score
- score_r_o  out  4  right score
- frame_valid_o  out  1  one-cycle pulse: outputs just updated
- frame_error_o  out  1  one-cycle pulse: frame dropped
- err_sync_o, err_csum_o, err_range_o, err_ovr_o  out  8 each  saturating error counters

## Operation
- Frame layout: b0 sync; b1 sequence; b2 paddle L; b3 paddle R; b4:b5 ball x big-endian; b6:b7 ball y big-endian; b8 scores (L = [7:4], R = [3:0]); b9 = XOR of b0..b8.
- FSM states: IDLE, CHECK, VALIDATE.
  - IDLE: a rising edge of data_ready_i (registered previous value low, current high) copies data_i into a local buffer, clears the accumulator and index, and moves to CHECK.
  - CHECK: XORs buffer[idx] into the accumulator for idx = 0..9, one byte per cycle, then moves to VALIDATE.
  - VALIDATE: evaluates all checks, commits or drops, and returns to IDLE.
- Error priority (exactly one counter increments per dropped frame):
  - sync: b0 != SYNC_BYTE.
  - checksum: accumulator != 0.
  - range: b4[7:2] != 0, b6[7:2] != 0, x > X_MAX, or y > Y_MAX.
  - seq: only when the sequence check is compiled in.
- Commit: all state outputs load together and frame_valid_o pulses. Drop: outputs hold their value, frame_error_o pulses, and the matching counter increments.
- A data_ready_i rising edge seen while not in IDLE is ignored and increments err_ovr_o. The frame in progress continues unaffected.
- Counters saturate at 8'hFF and never wrap.
- Reset (asynchronous, at any point, including mid-CHECK) returns the FSM to IDLE and clears every output, counter, the buffer, and the edge-detect register to 0.

## Timing
- Cycle N: rising edge sampled, buffer loaded.
- Cycles N+1..N+10: CHECK.
- Cycle N+11: VALIDATE.
- Cycle N+12: updated outputs and the frame_valid_o or frame_error_o pulse are visible. Fixed latency is 12 cycles.
- Back-to-back frames: a rising edge is accepted in the cycle after VALIDATE, so the minimum frame spacing is 12 cycles.
- data_ready_i held high does not retrigger. It must fall and rise again.
- frame_valid_o and frame_error_o are never high together and each lasts exactly 1 cycle.

## Configuration
- Macro PONG_SEQ_CHECK_EN.
- Defined:
  - Adds output err_seq_o (8-bit saturating) and a stored last-sequence register.
  - The first committed frame after reset is accepted with any b1.
  - After that, b1 must equal last+1 mod 256 (0xFF → 0x00 is legal), otherwise the frame is dropped as a seq error.
  - Seq error has the lowest priority.
  - last-sequence updates only on commit.
- Undefined: b1 is ignored, there is no err_seq_o port, and no sequence state exists.

## Structure
- Shared package pong_pkg:
  - frame byte index constants (IDX_SYNC … IDX_CSUM) and FRAME_BYTES = 10;
  - default SYNC_BYTE;
  - FSM state enum;
  - error-cause enum.
- One sub-module, pong_sat_counter: 8-bit counter with enable and async active-low clear that saturates at 255. One instance per error counter.

## Test plan
- Frame A5 01 40 80 01 3F 00 F0 32 98 → at N+12: frame_valid_o=1, paddle_l=0x40, paddle_r=0x80, ball_x=319, ball_y=240, score_l=3, score_r=2.
- Same frame with b9 = 0x99 → frame_error_o=1, err_csum_o=1, outputs unchanged.
- b0 = 0x5A with the checksum recomputed → err_sync_o increments. Frame with a bad sync and a bad checksum → only err_sync_o increments.
- Ball x = 0x0280 (640), checksum valid → err_range_o=1. Ball x = 0x027F → commit.
- Assert rst_n_i low at N+5, release, then send a valid frame → all outputs 0 after reset, and the new frame commits 12 cycles after its edge.
- Second data_ready_i rise at N+4 → err_ovr_o=1 and the first frame still commits at N+12. With PONG_SEQ_CHECK_EN, sequence numbers FF then 00 commit, and FF then 02 gives err_seq_o=1.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared definitions for the pong frame decoder: frame byte
//               layout, protocol constants, FSM state and error-cause enums,
//               and a coordinate range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Frame geometry and byte positions
  localparam int FRAME_BYTES    = 10;
  localparam int IDX_SYNC       = 0;
  localparam int IDX_SEQ        = 1;
  localparam int IDX_PADDLE_L   = 2;
  localparam int IDX_PADDLE_R   = 3;
  localparam int IDX_BALL_X_HI  = 4;
  localparam int IDX_BALL_X_LO  = 5;
  localparam int IDX_BALL_Y_HI  = 6;
  localparam int IDX_BALL_Y_LO  = 7;
  localparam int IDX_SCORE      = 8;
  localparam int IDX_CSUM       = 9;

  // Protocol constants
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [9:0] X_MAX     = 10'd639;
  localparam logic [9:0] Y_MAX     = 10'd479;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_VALIDATE = 2'd2
  } pong_state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_SYNC  = 3'd1,
    ERR_CSUM  = 3'd2,
    ERR_RANGE = 3'd3,
    ERR_SEQ   = 3'd4
  } pong_err_e;

  // A big-endian coordinate is out of range if any bit above the 10-bit
  // field is set, or if the 10-bit value exceeds the limit.
  function automatic logic coord_out_of_range(input logic [7:0] hi,
                                              input logic [7:0] lo,
                                              input logic [9:0] max_v);
    return (hi[7:2] != 6'd0) || ({hi[1:0], lo} > max_v);
  endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_frame_decoder_if
// Description : Frame hand-off between the SPI receive stage (master) and
//               the frame decoder (slave).
//   data       : FRAME_BYTES x 8-bit frame bytes, byte 0 first
//   data_ready : level, high while data holds a complete frame
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_frame_decoder_if;
  import pong_pkg::*;

  logic [7:0] data [0:FRAME_BYTES-1];
  logic       data_ready;

  modport master (output data, output data_ready);
  modport slave  (input  data, input  data_ready);

endinterface : pong_frame_decoder_if
`default_nettype wire

// File: rtl/pong_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pong_sat_counter
// Description : 8-bit event counter that sticks at 255 instead of wrapping.
//   clk_i   in  1  clock
//   clr_n_i in  1  asynchronous active-low clear
//   en_i    in  1  count enable (one increment per enabled cycle)
//   count_o out 8  current count
// Revision    : 1.0 - initial release
// ============================================================================
module pong_sat_counter (
  input  wire logic       clk_i,
  input  wire logic       clr_n_i,
  input  wire logic       en_i,
  output logic [7:0]      count_o
);

  localparam logic [7:0] c_COUNT_MAX = 8'hFF;

  logic [7:0] r_count;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_count <= 8'd0;
    end else if (en_i && (r_count != c_COUNT_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count_o = r_count;

endmodule : pong_sat_counter
`default_nettype wire

// File: rtl/pong_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pong_frame_decoder
// Description : Snapshots each new 10-byte frame from the SPI stage, walks
//               the XOR checksum over it one byte per cycle, checks sync and
//               coordinate ranges, then commits the game state or drops the
//               frame. Last good state is held indefinitely.
//               Fixed latency: 12 cycles from the sampled data_ready rise to
//               the frame_valid_o / frame_error_o pulse.
// Build option: PONG_SEQ_CHECK_EN - adds sequence-continuity checking and
//               the err_seq_o counter port.
// Ports:
//   sys_clk_i      in   1   system clock
//   rst_n_i        in   1   asynchronous active-low reset
//   frame_if       slave    frame bytes + data_ready level
//   paddle_l_o/r_o out  8   paddle y positions
//   ball_x_o/y_o   out  10  ball position
//   score_l_o/r_o  out  4   scores
//   frame_valid_o  out  1   one-cycle pulse, outputs just updated
//   frame_error_o  out  1   one-cycle pulse, frame dropped
//   err_*_o        out  8   saturating error counters
// Revision    : 1.0 - initial release
// ============================================================================
module pong_frame_decoder
  import pong_pkg::*;
(
  input  wire logic           sys_clk_i,
  input  wire logic           rst_n_i,
  pong_frame_decoder_if.slave frame_if,
  output logic [7:0]          paddle_l_o,
  output logic [7:0]          paddle_r_o,
  output logic [9:0]          ball_x_o,
  output logic [9:0]          ball_y_o,
  output logic [3:0]          score_l_o,
  output logic [3:0]          score_r_o,
  output logic                frame_valid_o,
  output logic                frame_error_o,
  output logic [7:0]          err_sync_o,
  output logic [7:0]          err_csum_o,
  output logic [7:0]          err_range_o,
  output logic [7:0]          err_ovr_o
`ifdef PONG_SEQ_CHECK_EN
  ,
  output logic [7:0]          err_seq_o
`endif
);

  localparam logic [3:0] c_LAST_IDX = 4'(FRAME_BYTES - 1);

  pong_state_e r_state;
  pong_state_e w_state_nxt;

  logic [7:0] r_buf [0:FRAME_BYTES-1];
  logic [7:0] r_acc;
  logic [3:0] r_idx;
  logic       r_ready_d;

  logic       w_rise;
  logic       w_load;
  logic       w_acc_en;
  logic       w_commit;
  logic       w_drop;
  logic       w_ovr;
  logic       w_sync_bad;
  logic       w_csum_bad;
  logic       w_range_bad;
  logic       w_seq_bad;
  pong_err_e  w_cause;

  // --------------------------------------------------------------------------
  // Edge detect on the data_ready level
  // --------------------------------------------------------------------------
  assign w_rise = frame_if.data_ready & ~r_ready_d;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ready_d <= 1'b0;
    end else begin
      r_ready_d <= frame_if.data_ready;
    end
  end

  // --------------------------------------------------------------------------
  // Frame checks, evaluated from the snapshot while in VALIDATE
  // --------------------------------------------------------------------------
  assign w_sync_bad  = (r_buf[IDX_SYNC] != SYNC_BYTE);
  // The accumulator includes the checksum byte, so a good frame folds to 0.
  assign w_csum_bad  = (r_acc != 8'd0);
  assign w_range_bad = coord_out_of_range(r_buf[IDX_BALL_X_HI], r_buf[IDX_BALL_X_LO], X_MAX) ||
                       coord_out_of_range(r_buf[IDX_BALL_Y_HI], r_buf[IDX_BALL_Y_LO], Y_MAX);

`ifdef PONG_SEQ_CHECK_EN
  logic [7:0] r_last_seq;
  logic       r_seq_seen;

  // The first commit after reset establishes the sequence baseline.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_seq <= 8'd0;
      r_seq_seen <= 1'b0;
    end else if (w_commit) begin
      r_last_seq <= r_buf[IDX_SEQ];
      r_seq_seen <= 1'b1;
    end
  end

  assign w_seq_bad = r_seq_seen && (r_buf[IDX_SEQ] != (r_last_seq + 8'd1));
`else
  assign w_seq_bad = 1'b0;
`endif

  // Exactly one cause is reported per dropped frame, highest priority first.
  always_comb begin
    w_cause = ERR_NONE;
    if (w_sync_bad) begin
      w_cause = ERR_SYNC;
    end else if (w_csum_bad) begin
      w_cause = ERR_CSUM;
    end else if (w_range_bad) begin
      w_cause = ERR_RANGE;
    end else if (w_seq_bad) begin
      w_cause = ERR_SEQ;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_acc_en    = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A new frame while busy is counted but never disturbs this one.
        w_ovr    = w_rise;
        w_acc_en = 1'b1;
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        w_ovr       = w_rise;
        w_state_nxt = ST_IDLE;
        if (w_cause == ERR_NONE) begin
          w_commit = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Snapshot buffer and checksum accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        r_buf[i] <= 8'd0;
      end
      r_acc <= 8'd0;
      r_idx <= 4'd0;
    end else if (w_load) begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        r_buf[i] <= frame_if.data[i];
      end
      r_acc <= 8'd0;
      r_idx <= 4'd0;
    end else if (w_acc_en) begin
      r_acc <= r_acc ^ r_buf[r_idx];
      r_idx <= r_idx + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Committed game state and status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      paddle_l_o    <= 8'd0;
      paddle_r_o    <= 8'd0;
      ball_x_o      <= 10'd0;
      ball_y_o      <= 10'd0;
      score_l_o     <= 4'd0;
      score_r_o     <= 4'd0;
      frame_valid_o <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      frame_valid_o <= w_commit;
      frame_error_o <= w_drop;
      if (w_commit) begin
        paddle_l_o <= r_buf[IDX_PADDLE_L];
        paddle_r_o <= r_buf[IDX_PADDLE_R];
        ball_x_o   <= {r_buf[IDX_BALL_X_HI][1:0], r_buf[IDX_BALL_X_LO]};
        ball_y_o   <= {r_buf[IDX_BALL_Y_HI][1:0], r_buf[IDX_BALL_Y_LO]};
        score_l_o  <= r_buf[IDX_SCORE][7:4];
        score_r_o  <= r_buf[IDX_SCORE][3:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error counters
  // --------------------------------------------------------------------------
  pong_sat_counter u_cnt_sync (
    .clk_i   (sys_clk_i),
    .clr_n_i (rst_n_i),
    .en_i    (w_drop && (w_cause == ERR_SYNC)),
    .count_o (err_sync_o)
  );

  pong_sat_counter u_cnt_csum (
    .clk_i   (sys_clk_i),
    .clr_n_i (rst_n_i),
    .en_i    (w_drop && (w_cause == ERR_CSUM)),
    .count_o (err_csum_o)
  );

  pong_sat_counter u_cnt_range (
    .clk_i   (sys_clk_i),
    .clr_n_i (rst_n_i),
    .en_i    (w_drop && (w_cause == ERR_RANGE)),
    .count_o (err_range_o)
  );

  pong_sat_counter u_cnt_ovr (
    .clk_i   (sys_clk_i),
    .clr_n_i (rst_n_i),
    .en_i    (w_ovr),
    .count_o (err_ovr_o)
  );

`ifdef PONG_SEQ_CHECK_EN
  pong_sat_counter u_cnt_seq (
    .clk_i   (sys_clk_i),
    .clr_n_i (rst_n_i),
    .en_i    (w_drop && (w_cause == ERR_SEQ)),
    .count_o (err_seq_o)
  );
`endif

endmodule : pong_frame_decoder
`default_nettype wire

// File: tb/tb_pong_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_frame_decoder
// Description : Scoreboard bench for pong_frame_decoder. Stimulus pushes the
//               expected response (outputs, counters, arrival cycle) into a
//               queue; a negedge monitor pops and compares on every
//               frame_valid_o / frame_error_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_frame_decoder;
  import pong_pkg::*;

  typedef enum {K_OK, K_SYNC, K_CSUM, K_RANGE, K_SEQ} kind_e;

  typedef struct {
    bit          is_valid;
    logic [7:0]  pl;
    logic [7:0]  pr;
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic [7:0]  c_sync;
    logic [7:0]  c_csum;
    logic [7:0]  c_range;
    logic [7:0]  c_ovr;
    logic [7:0]  c_seq;
    int unsigned at;
  } exp_t;

  logic       sys_clk_i = 1'b0;
  logic       rst_n_i   = 1'b0;
  logic [7:0] paddle_l_o, paddle_r_o;
  logic [9:0] ball_x_o, ball_y_o;
  logic [3:0] score_l_o, score_r_o;
  logic       frame_valid_o, frame_error_o;
  logic [7:0] err_sync_o, err_csum_o, err_range_o, err_ovr_o;
  logic [7:0] err_seq_o;

  pong_frame_decoder_if frame_if ();

  pong_frame_decoder dut (
    .sys_clk_i     (sys_clk_i),
    .rst_n_i       (rst_n_i),
    .frame_if      (frame_if),
    .paddle_l_o    (paddle_l_o),
    .paddle_r_o    (paddle_r_o),
    .ball_x_o      (ball_x_o),
    .ball_y_o      (ball_y_o),
    .score_l_o     (score_l_o),
    .score_r_o     (score_r_o),
    .frame_valid_o (frame_valid_o),
    .frame_error_o (frame_error_o),
    .err_sync_o    (err_sync_o),
    .err_csum_o    (err_csum_o),
    .err_range_o   (err_range_o),
    .err_ovr_o     (err_ovr_o)
`ifdef PONG_SEQ_CHECK_EN
    ,
    .err_seq_o     (err_seq_o)
`endif
  );

`ifndef PONG_SEQ_CHECK_EN
  assign err_seq_o = 8'd0;
`endif

  always #5 sys_clk_i = ~sys_clk_i;

  int unsigned cyc = 0;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Reference state
  logic [7:0] m_pl, m_pr, m_sync, m_csum, m_range, m_ovr, m_seq, m_last_seq;
  logic [9:0] m_bx, m_by;
  logic [3:0] m_sl, m_sr;
  bit         m_seq_seen;

  // Hand-built frames (byte 0 in the top byte); checksums computed by hand
  localparam logic [79:0] F_BASE   = 80'hA5_01_40_80_01_3F_00_F0_32_98; // x=319 y=240
  localparam logic [79:0] F_BADCS  = 80'hA5_01_40_80_01_3F_00_F0_32_99;
  localparam logic [79:0] F_SYNC   = 80'h5A_01_40_80_01_3F_00_F0_32_67;
  localparam logic [79:0] F_SYNCCS = 80'h5A_01_40_80_01_3F_00_F0_32_98;
  localparam logic [79:0] F_X640   = 80'hA5_01_40_80_02_80_00_F0_32_24;
  localparam logic [79:0] F_X639   = 80'hA5_01_40_80_02_7F_00_F0_32_DB;
  localparam logic [79:0] F_Y480   = 80'hA5_01_40_80_02_7F_01_E0_32_CA;
  localparam logic [79:0] F_Y479   = 80'hA5_01_40_80_02_7F_01_DF_32_F5;
  localparam logic [79:0] F_ALT    = 80'hA5_07_11_22_00_00_00_00_F0_61;
  localparam logic [79:0] F_XHI    = 80'hA5_07_11_22_04_00_00_00_F0_65; // x hi bits set
  localparam logic [79:0] F_YHI    = 80'hA5_07_11_22_00_00_FC_00_F0_9D; // y hi bits set
  localparam logic [79:0] F_SEQFF  = 80'hA5_FF_11_22_00_00_00_00_F0_99;
  localparam logic [79:0] F_SEQ00  = 80'hA5_00_11_22_00_00_00_00_F0_66;
  localparam logic [79:0] F_SEQ02  = 80'hA5_02_11_22_00_00_00_00_F0_64;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pl = 0; m_pr = 0; m_bx = 0; m_by = 0; m_sl = 0; m_sr = 0;
    m_sync = 0; m_csum = 0; m_range = 0; m_ovr = 0; m_seq = 0;
    m_last_seq = 0; m_seq_seen = 0;
  endtask

  task automatic drive_bytes(input logic [79:0] f);
    for (int i = 0; i < FRAME_BYTES; i++) frame_if.data[i] = f[79-8*i -: 8];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_paddle_l"}, paddle_l_o, 0);
    check({tag, "_paddle_r"}, paddle_r_o, 0);
    check({tag, "_ball_x"}, ball_x_o, 0);
    check({tag, "_ball_y"}, ball_y_o, 0);
    check({tag, "_scores"}, {score_l_o, score_r_o}, 0);
    check({tag, "_pulses"}, {frame_valid_o, frame_error_o}, 0);
    check({tag, "_err_sync"}, err_sync_o, 0);
    check({tag, "_err_csum"}, err_csum_o, 0);
    check({tag, "_err_range"}, err_range_o, 0);
    check({tag, "_err_ovr"}, err_ovr_o, 0);
    check({tag, "_err_seq"}, err_seq_o, 0);
  endtask

  // Drive a frame rise after the next posedge; optionally queue its result.
  task automatic issue(input logic [79:0] f, input kind_e k,
                       input logic [7:0] pl, input logic [7:0] pr,
                       input logic [9:0] bx, input logic [9:0] by,
                       input logic [3:0] sl, input logic [3:0] sr, input bit push);
    kind_e kk;
    exp_t  e;
    @(posedge sys_clk_i);
    #1;
    drive_bytes(f);
    frame_if.data_ready = 1'b1;
    if (push) begin
      kk = k;
`ifdef PONG_SEQ_CHECK_EN
      if (kk == K_OK && m_seq_seen && (f[71:64] != (m_last_seq + 8'd1))) kk = K_SEQ;
`endif
      case (kk)
        K_OK: begin
          m_pl = pl; m_pr = pr; m_bx = bx; m_by = by; m_sl = sl; m_sr = sr;
          m_last_seq = f[71:64]; m_seq_seen = 1;
        end
        K_SYNC:  m_sync  = sat_inc(m_sync);
        K_CSUM:  m_csum  = sat_inc(m_csum);
        K_RANGE: m_range = sat_inc(m_range);
        default: m_seq   = sat_inc(m_seq);
      endcase
      e.is_valid = (kk == K_OK);
      e.pl = m_pl; e.pr = m_pr; e.bx = m_bx; e.by = m_by; e.sl = m_sl; e.sr = m_sr;
      e.c_sync = m_sync; e.c_csum = m_csum; e.c_range = m_range;
      e.c_ovr = m_ovr; e.c_seq = m_seq;
      e.at = cyc + 12;
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input logic [79:0] f, input kind_e k,
                      input logic [7:0] pl, input logic [7:0] pr,
                      input logic [9:0] bx, input logic [9:0] by,
                      input logic [3:0] sl, input logic [3:0] sr, input int hold);
    issue(f, k, pl, pr, bx, by, sl, sr, 1'b1);
    repeat (hold) @(posedge sys_clk_i);
    #1 frame_if.data_ready = 1'b0;
    repeat (12) @(posedge sys_clk_i);
  endtask

  // Monitor
  always @(negedge sys_clk_i) begin
    exp_t e;
    if (rst_n_i && (frame_valid_o || frame_error_o)) begin
      check("pulse_exclusive", {31'd0, frame_valid_o & frame_error_o}, 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b, expected no pulse (t=%0t)",
                 frame_valid_o, frame_error_o, $time);
      end else begin
        e = sb_q.pop_front();
        check("outcome_valid", {31'd0, frame_valid_o}, {31'd0, e.is_valid});
        check("latency_cycle", cyc, e.at);
        check("paddle_l", paddle_l_o, e.pl);
        check("paddle_r", paddle_r_o, e.pr);
        check("ball_x", ball_x_o, e.bx);
        check("ball_y", ball_y_o, e.by);
        check("score_l", score_l_o, e.sl);
        check("score_r", score_r_o, e.sr);
        check("err_sync", err_sync_o, e.c_sync);
        check("err_csum", err_csum_o, e.c_csum);
        check("err_range", err_range_o, e.c_range);
        check("err_ovr", err_ovr_o, e.c_ovr);
        check("err_seq", err_seq_o, e.c_seq);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_if.data_ready = 1'b0;
    drive_bytes(80'd0);
    model_reset();

    // Reset state
    repeat (3) @(posedge sys_clk_i);
    @(negedge sys_clk_i);
    check_all_zero("reset");
    @(posedge sys_clk_i);
    #1 rst_n_i = 1'b1;

    // Main function and boundaries
    send(F_BASE,   K_OK,    8'h40, 8'h80, 10'd319, 10'd240, 4'd3, 4'd2, 2);
    send(F_BADCS,  K_CSUM,  0, 0, 0, 0, 0, 0, 2);
    send(F_SYNC,   K_SYNC,  0, 0, 0, 0, 0, 0, 2);
    send(F_SYNCCS, K_SYNC,  0, 0, 0, 0, 0, 0, 2);
    send(F_X640,   K_RANGE, 0, 0, 0, 0, 0, 0, 2);
    send(F_X639,   K_OK,    8'h40, 8'h80, 10'd639, 10'd240, 4'd3, 4'd2, 2);
    send(F_Y480,   K_RANGE, 0, 0, 0, 0, 0, 0, 2);
    send(F_Y479,   K_OK,    8'h40, 8'h80, 10'd639, 10'd479, 4'd3, 4'd2, 2);
    send(F_XHI,    K_RANGE, 0, 0, 0, 0, 0, 0, 2);
    send(F_YHI,    K_RANGE, 0, 0, 0, 0, 0, 0, 2);
    // Held high well past completion: must not retrigger
    send(F_ALT,    K_OK,    8'h11, 8'h22, 10'd0, 10'd0, 4'hF, 4'h0, 25);

    // Overrun: second rise sampled at N+4 with different data on the bus
    issue(F_BASE, K_OK, 8'h40, 8'h80, 10'd319, 10'd240, 4'd3, 4'd2, 1'b1);
    repeat (2) @(posedge sys_clk_i);
    #1 frame_if.data_ready = 1'b0;
    repeat (2) @(posedge sys_clk_i);
    #1;
    drive_bytes(F_BADCS);
    frame_if.data_ready = 1'b1;
    m_ovr = sat_inc(m_ovr);
    sb_q[sb_q.size()-1].c_ovr = m_ovr;
    repeat (4) @(posedge sys_clk_i);
    #1 frame_if.data_ready = 1'b0;
    repeat (12) @(posedge sys_clk_i);

    // Reset in the middle of CHECK, then a fresh frame
    issue(F_BASE, K_OK, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge sys_clk_i);
    #1 frame_if.data_ready = 1'b0;
    repeat (4) @(posedge sys_clk_i);
    #1 rst_n_i = 1'b0;
    @(negedge sys_clk_i);
    check_all_zero("midreset");
    repeat (2) @(posedge sys_clk_i);
    #1 rst_n_i = 1'b1;
    model_reset();
    repeat (14) @(posedge sys_clk_i);
    send(F_ALT, K_OK, 8'h11, 8'h22, 10'd0, 10'd0, 4'hF, 4'h0, 2);

`ifdef PONG_SEQ_CHECK_EN
    // Sequence continuity from a fresh reset: FF, 00 commit; 02 is a gap
    #1 rst_n_i = 1'b0;
    repeat (2) @(posedge sys_clk_i);
    #1 rst_n_i = 1'b1;
    model_reset();
    send(F_SEQFF, K_OK, 8'h11, 8'h22, 10'd0, 10'd0, 4'hF, 4'h0, 2);
    send(F_SEQ00, K_OK, 8'h11, 8'h22, 10'd0, 10'd0, 4'hF, 4'h0, 2);
    send(F_SEQ02, K_SEQ, 0, 0, 0, 0, 0, 0, 2);
`endif

    // Saturation of the checksum counter
    for (int i = 0; i < 256; i++) begin
      send(F_BADCS, K_CSUM, 0, 0, 0, 0, 0, 0, 2);
    end

    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge sys_clk_i);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pong_frame_decoder
`default_nettype wire
